uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART serialiser for the video-transport control link. It replaces the fixed 8-bit, externally-clocked transmitter with one that has an internal baud counter, a valid/ready input handshake, configurable data width and bit order, optional parity, and 1 or 2 stop bits. It sits between the command/status packer and the board TX pin, one frame per accepted word.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9
CLKS_PER_BIT, 868, clk cycles per bit period; legal >= 2 (868 = 115200 baud at 100 MHz)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; legal 1 or 2
MSB_FIRST, 1, 1 = data MSB sent first, 0 = LSB first

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  DATA_WIDTH  word to send; sampled only on accept
tx_valid  in  1  tx_data valid
tx_ready  out  1  block can accept; high only in IDLE
tx_out  out  1  serial line, idle high
tx_busy  out  1  high from the cycle after accept through the last stop-bit cycle
tx_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, rst_n low): state IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, baud counter=0, shift reg=0. Takes effect immediately, including mid-frame. The aborted frame produces no tx_done.
- Accept: a rising edge with state IDLE and tx_valid=1. At that edge tx_data is latched into the shift register (bit-reversed internally if MSB_FIRST=1), parity is computed and latched, the baud counter is cleared, and the state moves to START.
- States: IDLE -> START -> DATA (DATA_WIDTH bits) -> PARITY (skipped if PARITY_MODE=0) -> STOP (STOP_BITS periods) -> IDLE.
- Each bit period is exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1, and the state/bit advances on the cycle the counter reaches CLKS_PER_BIT-1. A bit index counts data bits and stop bits.
- tx_out is registered and glitch-free. Level per state: 0 in START, current shift-reg bit 0 in DATA (shift right each period), parity bit in PARITY, 1 in STOP and IDLE.
- Parity: even = XOR of all data bits; odd = inverted XOR.
- Frame length = (1 + DATA_WIDTH + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT cycles. The first tx_out=0 cycle is the cycle after accept.
- tx_done and the return to IDLE occur together in the first cycle after the last stop-bit cycle. In that cycle tx_ready=1 and tx_busy=0.
- Back-to-back: with tx_valid held high, the next accept happens at the end of the tx_done cycle. The line therefore idles high for exactly 1 cycle between frames.
- tx_valid and tx_data are ignored while not IDLE. Changing tx_data mid-frame has no effect on the frame in flight.
- Illegal parameter values are out of scope. The implementation must flag them with an elaboration-time check.

Test Plan:
- Default widths, CLKS_PER_BIT=4, PARITY_MODE=0, STOP_BITS=1, MSB_FIRST=1; accept 0xA5 at cycle 0 -> tx_out low cycles 1-4; data 1,0,1,0,0,1,0,1 in 4-cycle slots (cycles 5-36); high 37-40; tx_done=1 only in cycle 41 with tx_ready=1; tx_busy high cycles 1-40.
- MSB_FIRST=0, PARITY_MODE=1, 0x07 -> data 1,1,1,0,0,0,0,0 then parity 1; tx_done at cycle 45. Same with PARITY_MODE=2 -> parity 0.
- STOP_BITS=2, 0xFF, no parity -> line high for the 8 cycles after the last data bit; tx_done at cycle 45.
- tx_valid held high with 0x55 then 0xAA -> second start bit begins cycle 42, exactly one idle-high cycle after the first frame; both frames bit-exact; two tx_done pulses, 41 cycles apart.
- rst_n low for 3 cycles during data bit 3 -> tx_out=1 in the same cycle reset asserts, no tx_done, tx_ready=1; a following 0x3C frame is bit-exact.
- tx_data toggled every cycle while busy, tx_valid high -> transmitted frame equals the value at the accept edge only; DATA_WIDTH=5 run with 0x15 sends 5 data bits, frame of 7 periods.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: internal baud counter, valid/ready input,
// configurable data width, bit order, parity and stop-bit count.
module uart_tx_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CLKS_PER_BIT < 2 ||
            PARITY_MODE < 0 || PARITY_MODE > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 ||
            MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_param_check
            $error("uart_tx_param: illegal parameter value");
        end
    endgenerate

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Handshake: a word is taken on any rising edge where tx_valid and
    // tx_ready are both high; tx_ready is high exactly while in IDLE.
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [3:0]            r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_parity;
    logic                  w_bit_end;

    // The shift register always emits bit 0 first, so MSB-first words are reversed on load.
    always_comb begin
        w_load = tx_data;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                w_load[i] = tx_data[DATA_WIDTH-1-i];
            end
        end
    end

    assign w_parity  = (^tx_data) ^ (PARITY_MODE == 2);
    assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        r_shift  <= w_load;
                        r_parity <= w_parity;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_tx     <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == 4'(DATA_WIDTH - 1)) begin
                            r_idx <= '0;
                            if (PARITY_MODE != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Completion cycle: back in IDLE with tx_done, so a held tx_valid is accepted at its end.
                    if (w_bit_end) begin
                        if (r_idx == 4'(STOP_BITS - 1)) begin
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = r_ready;
    assign tx_out   = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: six instances with different parameter sets, each
// checked cycle by cycle against a frame model built from the line protocol.
module tb_uart_tx_param;

    localparam int N = 6;

    function automatic int cfg_dw(input int k);
        case (k)
            4:       return 5;
            5:       return 9;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_cpb(input int k);
        case (k)
            5:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_par(input int k);
        case (k)
            1:       return 1;
            2:       return 2;
            5:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_stop(input int k);
        case (k)
            3:       return 2;
            5:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_msb(input int k);
        case (k)
            1:       return 0;
            2:       return 0;
            5:       return 0;
            default: return 1;
        endcase
    endfunction

    logic         clk;
    logic         rst_n;
    logic [8:0]   drv_data [N];
    logic [N-1:0] drv_valid;
    logic [N-1:0] w_ready;
    logic [N-1:0] w_out;
    logic [N-1:0] w_busy;
    logic [N-1:0] w_done;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [cfg_dw(g)-1:0] w_d;
        assign w_d = drv_data[g][cfg_dw(g)-1:0];
        uart_tx_param #(
            .DATA_WIDTH  (cfg_dw(g)),
            .CLKS_PER_BIT(cfg_cpb(g)),
            .PARITY_MODE (cfg_par(g)),
            .STOP_BITS   (cfg_stop(g)),
            .MSB_FIRST   (cfg_msb(g))
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .tx_data (w_d),
            .tx_valid(drv_valid[g]),
            .tx_ready(w_ready[g]),
            .tx_out  (w_out[g]),
            .tx_busy (w_busy[g]),
            .tx_done (w_done[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_nbits(input int k);
        return 1 + cfg_dw(k) + ((cfg_par(k) != 0) ? 1 : 0) + cfg_stop(k);
    endfunction

    // Line levels of one frame, bit i = i-th bit period on the wire.
    function automatic logic [15:0] frame_bits(input int k, input logic [8:0] d);
        logic q[$];
        logic [15:0] r;
        logic p;
        int j;
        p = 1'b0;
        q.push_back(1'b0);
        for (int i = 0; i < cfg_dw(k); i++) begin
            j = (cfg_msb(k) != 0) ? cfg_dw(k) - 1 - i : i;
            q.push_back(d[j]);
            p = p ^ d[j];
        end
        if (cfg_par(k) != 0) q.push_back((cfg_par(k) == 2) ? ~p : p);
        for (int s = 0; s < cfg_stop(k); s++) q.push_back(1'b1);
        r = '0;
        foreach (q[i]) r[i] = q[i];
        return r;
    endfunction

    function automatic logic [8:0] rand_word(input int k);
        logic [8:0] m;
        m = 9'((1 << cfg_dw(k)) - 1);
        return 9'($urandom) & m;
    endfunction

    // Sends n words back to back with tx_valid held; data is scrambled while busy.
    task automatic send_words(input int k, input int n, input logic [8:0] w [4]);
        int cpb;
        int len;
        logic [15:0] fb;
        string t;
        cpb = cfg_cpb(k);
        len = frame_nbits(k) * cpb;
        @(posedge clk); #1;
        drv_valid[k] = 1'b1;
        drv_data[k]  = w[0];
        @(negedge clk);
        check($sformatf("i%0d ready_before", k), 32'(w_ready[k]), 32'd1);
        for (int i = 0; i < n; i++) begin
            fb = frame_bits(k, w[i]);
            for (int c = 1; c <= len; c++) begin
                @(posedge clk); #1;
                if (c == len) begin
                    if (i < n - 1) begin
                        drv_data[k]  = w[i+1];
                        drv_valid[k] = 1'b1;
                    end else begin
                        drv_data[k]  = 9'($urandom);
                        drv_valid[k] = 1'b0;
                    end
                end else begin
                    drv_data[k]  = 9'($urandom);
                    drv_valid[k] = 1'b1;
                end
                @(negedge clk);
                t = $sformatf("i%0d w%0d=%0h c%0d", k, i, w[i], c);
                check({t, " tx_out"}, 32'(w_out[k]), 32'(fb[(c-1)/cpb]));
                check({t, " busy"}, 32'(w_busy[k]), 32'd1);
                check({t, " done"}, 32'(w_done[k]), 32'd0);
                check({t, " ready"}, 32'(w_ready[k]), 32'd0);
            end
            @(posedge clk); #1;
            @(negedge clk);
            t = $sformatf("i%0d w%0d end", k, i);
            check({t, " done"}, 32'(w_done[k]), 32'd1);
            check({t, " ready"}, 32'(w_ready[k]), 32'd1);
            check({t, " busy"}, 32'(w_busy[k]), 32'd0);
            check({t, " tx_out"}, 32'(w_out[k]), 32'd1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("i%0d idle done", k), 32'(w_done[k]), 32'd0);
        check($sformatf("i%0d idle tx_out", k), 32'(w_out[k]), 32'd1);
        check($sformatf("i%0d idle ready", k), 32'(w_ready[k]), 32'd1);
        check($sformatf("i%0d idle busy", k), 32'(w_busy[k]), 32'd0);
    endtask

    task automatic check_idle_all(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s i%0d tx_out", tag, k), 32'(w_out[k]), 32'd1);
            check($sformatf("%s i%0d ready", tag, k), 32'(w_ready[k]), 32'd1);
            check($sformatf("%s i%0d busy", tag, k), 32'(w_busy[k]), 32'd0);
            check($sformatf("%s i%0d done", tag, k), 32'(w_done[k]), 32'd0);
        end
    endtask

    initial begin
        logic [8:0] w [4];
        int n;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        drv_valid = '0;
        for (int k = 0; k < N; k++) drv_data[k] = '0;

        repeat (3) @(negedge clk);
        check_idle_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_all("post_reset");

        w = '{9'h0A5, 9'h0, 9'h0, 9'h0};
        send_words(0, 1, w);
        w = '{9'h007, 9'h0, 9'h0, 9'h0};
        send_words(1, 1, w);
        send_words(2, 1, w);
        w = '{9'h0FF, 9'h0, 9'h0, 9'h0};
        send_words(3, 1, w);
        w = '{9'h055, 9'h0AA, 9'h0, 9'h0};
        send_words(0, 2, w);

        // Reset in the middle of data bit 3 of 0xA5 (cycles 17-20 after accept).
        @(posedge clk); #1;
        drv_valid[0] = 1'b1;
        drv_data[0]  = 9'h0A5;
        @(posedge clk); #1;
        drv_valid[0] = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        check("rst_mid pre tx_out", 32'(w_out[0]), 32'd0);
        check("rst_mid pre busy", 32'(w_busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid tx_out", 32'(w_out[0]), 32'd1);
        check("rst_mid ready", 32'(w_ready[0]), 32'd1);
        check("rst_mid busy", 32'(w_busy[0]), 32'd0);
        check("rst_mid done", 32'(w_done[0]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold done", 32'(w_done[0]), 32'd0);
            check("rst_hold tx_out", 32'(w_out[0]), 32'd1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel done", 32'(w_done[0]), 32'd0);
        w = '{9'h03C, 9'h0, 9'h0, 9'h0};
        send_words(0, 1, w);

        w = '{9'h015, 9'h0, 9'h0, 9'h0};
        send_words(4, 1, w);

        for (int k = 0; k < N; k++) begin
            for (int it = 0; it < 3; it++) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < 4; i++) w[i] = rand_word(k);
                send_words(k, n, w);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
